signed_add_arbiter: RTL and testbench

SIGNED_ADD_ARBITER -- requirements
Module: signed_add_arbiter

---
 rtl/signed_add_arbiter.sv | 112 +++++++++++
 tb/tb_signed_add_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_add_arbiter.sv
// Two-requester round-robin arbiter feeding a registered 4-bit signed adder with an overflow counter.
// Latency 1 from accept to res_valid; a stalled result (res_ready=0) holds the register and blocks both requesters.
module signed_add_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_sum,
  output logic       res_ovf,
  output logic       res_id,
  output logic [7:0] ovf_cnt,
  input  logic       ovf_clr
);

  typedef enum logic {IDLE, FULL} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [4:0] sum_q, sum_d;
  logic       ovf_q, ovf_d;
  logic       id_q, id_d;
  logic [7:0] cnt_q, cnt_d;

  logic       grant;
  logic       can_accept;
  logic       accept;
  logic       deliver;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [4:0] new_sum;

  // Under contention the requester not served last wins; otherwise the lone valid one.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_accept = (state_q == IDLE) || res_ready;
  assign req0_ready = can_accept && req0_valid && !grant;
  assign req1_ready = can_accept && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign deliver    = (state_q == FULL) && res_ready;

  assign sel_a   = grant ? req1_a : req0_a;
  assign sel_b   = grant ? req1_b : req0_b;
  assign new_sum = {sel_a[3], sel_a} + {sel_b[3], sel_b};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    cnt_d   = cnt_q;

    if (accept) begin
      state_d = FULL;
      last_d  = grant;
      sum_d   = new_sum;
      ovf_d   = new_sum[4] ^ new_sum[3];
      id_d    = grant;
    end else if (deliver) begin
      state_d = IDLE;
    end

    // Clear takes priority over a coincident counted delivery.
    if (ovf_clr) begin
      cnt_d = 8'd0;
    end else if (deliver && ovf_q && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= !PRIO_RESET;
      sum_q   <= 5'd0;
      ovf_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_ovf   = ovf_q;
  assign res_id    = id_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed-vector bench for signed_add_arbiter with PRIO_RESET=0.
module tb_signed_add_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_ready;
  logic [4:0] res_sum;
  logic       res_ovf, res_id;
  logic [7:0] ovf_cnt;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  signed_add_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .ovf_cnt    (ovf_cnt),
    .ovf_clr    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [4:0] s,
                         input logic o, input logic id);
    chk({tag, "_valid"}, 8'(res_valid), 8'(v));
    chk({tag, "_sum"},   8'(res_sum),   8'(s));
    chk({tag, "_ovf"},   8'(res_ovf),   8'(o));
    chk({tag, "_id"},    8'(res_id),    8'(id));
  endtask

  initial begin
    logic g;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    res_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state
    #12;
    chk_res("rst", 1'b0, 5'd0, 1'b0, 1'b0);
    chk("rst_cnt", ovf_cnt, 8'd0);

    // Single requester, first edge after reset release accepts
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0100;
    #1;
    chk("single_rdy0", 8'(req0_ready), 8'd1);
    chk("single_rdy1", 8'(req1_ready), 8'd0);
    step();
    req0_valid = 1'b0;
    chk_res("single", 1'b1, 5'b00111, 1'b0, 1'b0);
    res_ready = 1'b1;
    step();
    chk("single_drain", 8'(res_valid), 8'd0);
    chk("single_cnt", ovf_cnt, 8'd0);

    // Overflow vectors, back-to-back through requester 1
    req1_valid = 1'b1; req1_a = 4'b0111; req1_b = 4'b0001;
    step();
    chk_res("ovf_a", 1'b1, 5'b01000, 1'b1, 1'b1);
    req1_a = 4'b1000; req1_b = 4'b1000;
    #1;
    chk("ovf_b2b_rdy1", 8'(req1_ready), 8'd1);
    step();
    chk_res("ovf_b", 1'b1, 5'b10000, 1'b1, 1'b1);
    chk("ovf_cnt1", ovf_cnt, 8'd1);
    req1_a = 4'b1111; req1_b = 4'b1000;
    step();
    chk_res("ovf_c", 1'b1, 5'b10111, 1'b1, 1'b1);
    chk("ovf_cnt2", ovf_cnt, 8'd2);
    req1_valid = 1'b0;
    step();
    chk("ovf_drain", 8'(res_valid), 8'd0);
    chk("ovf_cnt3", ovf_cnt, 8'd3);

    // Contention: last served was 1, so order is 0,1,0,1
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2;
    for (int i = 0; i < 4; i++) begin
      g = 1'(i % 2);
      #1;
      chk("cont_rdy0", 8'(req0_ready), 8'(!g));
      chk("cont_rdy1", 8'(req1_ready), 8'(g));
      step();
      chk_res("cont", 1'b1, g ? 5'd4 : 5'd2, 1'b0, g);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("cont_drain", 8'(res_valid), 8'd0);
    chk("cont_cnt", ovf_cnt, 8'd3);

    // Backpressure: hold 5 cycles, operand changes ignored
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
    res_ready = 1'b0;
    step();
    chk_res("bp_load", 1'b1, 5'd3, 1'b0, 1'b0);
    req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6;
    for (int i = 0; i < 5; i++) begin
      req0_a = 4'(i + 5); req0_b = 4'(i + 9);
      #1;
      chk("bp_rdy0", 8'(req0_ready), 8'd0);
      chk("bp_rdy1", 8'(req1_ready), 8'd0);
      step();
      chk_res("bp_hold", 1'b1, 5'd3, 1'b0, 1'b0);
    end
    req0_valid = 1'b0;
    req1_a = 4'd2; req1_b = 4'd3;
    res_ready = 1'b1;
    #1;
    chk("bp_rel_rdy1", 8'(req1_ready), 8'd1);
    step();
    req1_valid = 1'b0;
    chk_res("bp_new", 1'b1, 5'd5, 1'b0, 1'b1);
    step();
    chk("bp_drain", 8'(res_valid), 8'd0);

    // Counter: clear, then 256 overflowing deliveries saturate at 255
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("cnt_clr", ovf_cnt, 8'd0);
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd7;
    for (int i = 1; i <= 257; i++) begin
      step();
      if (i == 101) chk("cnt_100", ovf_cnt, 8'd100);
    end
    chk_res("cnt_last", 1'b1, 5'b01110, 1'b1, 1'b0);
    chk("cnt_sat", ovf_cnt, 8'd255);
    req0_valid = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("cnt_clr_wins", ovf_cnt, 8'd0);
    chk("cnt_clr_drain", 8'(res_valid), 8'd0);

    // Mid-operation reset while FULL, last served left at 0
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1;
    res_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    res_ready = 1'b1;
    step();
    chk("mrst_cnt_pre", ovf_cnt, 8'd1);
    req0_valid = 1'b1;
    res_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    chk_res("mrst_full", 1'b1, 5'b01000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 8'(res_valid), 8'd0);
    chk("mrst_cnt", ovf_cnt, 8'd0);
    chk("mrst_sum", 8'(res_sum), 8'd0);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd0;
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd0;
    #1;
    chk("mrst_rdy0", 8'(req0_ready), 8'd1);
    chk("mrst_rdy1", 8'(req1_ready), 8'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk_res("mrst_grant", 1'b1, 5'd1, 1'b0, 1'b0);
    chk("mrst_cnt_post", ovf_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
